digit_msg_seq: RTL and testbench
================================

Name: digit_msg_seq

Overview:
- Parametrised multi-digit message store and sequencer for the seven-segment display path. Drives DIGITS BCD-coded 4-bit digit registers (code 10 = blank) into the downstream segment decoders.
- Holds ENTRIES messages in a writable table instead of fixed constants.
- Selects the displayed message either manually from an external select or automatically, advancing after a programmable dwell counted in tick pulses.

Parameters:
- DIGITS, 6, number of 4-bit digit outputs; digit 0 is least significant (rightmost).
- ENTRIES, 8, number of stored messages; must be 2 or more.
- SEL_W, 3, width of entry indices; 2**SEL_W must be at least ENTRIES.
- DWELL_W, 16, width of the dwell counter and dwell input.
- BLANK, 10, digit code meaning "segment off".

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- mode  in  1  0 = manual select, 1 = auto cycle.
- sel  in  SEL_W  manual entry select.
- tick  in  1  single-cycle timebase enable for dwell counting.
- dwell  in  DWELL_W  ticks per entry in auto mode; 0 is treated as 1.
- wr_en  in  1  table write strobe.
- wr_entry  in  SEL_W  entry to write.
- wr_digit  in  SEL_W  digit index to write.
- wr_data  in  4  digit code to write.
- digits  out  4*DIGITS  digit i on bits [4i+3:4i].
- cur_entry  out  SEL_W  entry currently displayed.
- wrap  out  1  one-cycle pulse when auto mode wraps from ENTRIES-1 to 0.

Behaviour:
- Reset (asynchronous, active-high):
  - Every digit output = 8 (lamp test).
  - Every table cell = BLANK.
  - cur_entry = 0, dwell counter = 0, wrap = 0.
- After reset release: the first rising edge loads digits from table[next_entry]. Lamp test therefore lasts until that first edge.
- Table writes:
  - Take effect on the rising edge where wr_en = 1.
  - Writes with wr_entry >= ENTRIES or wr_digit >= DIGITS are ignored.
  - Digits read the table contents from before the edge. A write to the displayed entry appears on digits one edge after the write edge. This is fixed read-before-write, 1 cycle latency.
- Digit register: every edge, digits <= table[next_entry] and cur_entry <= next_entry. Digits always correspond to cur_entry.
- Manual mode (mode = 0):
  - next_entry = sel when sel < ENTRIES; otherwise next_entry = cur_entry (hold).
  - Dwell counter is held at 0; wrap = 0.
- Auto mode (mode = 1), states COUNT and ADVANCE (ADVANCE is a single-edge action):
  - COUNT: on an edge with tick = 1, the counter increments.
  - When tick = 1 and counter == max(dwell,1)-1: the counter clears and next_entry = cur_entry+1, wrapping ENTRIES-1 -> 0.
  - wrap pulses high for exactly the edge on which the 0 entry is loaded.
  - tick = 0: counter and entry hold.
  - dwell changed mid-count so that counter >= new dwell: advance on the next tick, then clear.
  - sel is ignored.
- Mode 1 -> 0: on that edge next_entry = sel (subject to the range check) and the counter clears.
- Mode 0 -> 1: cycling starts from the current entry with the counter at 0.
- Simultaneous events: a write plus an advance on the same edge follow the read-before-write rule. tick has no effect in manual mode.
- Reset asserted mid-operation returns all state to the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: LZ_BLANK_EN.
- Defined: leading-zero suppression on the output. Starting at digit DIGITS-1 and moving down, each consecutive digit whose code is 0 is output as BLANK. Digit 0 is never suppressed.
  - The suppression is combinational on the registered digits, so latency is unchanged.
  - The reset value of 8 is unaffected.
- Undefined: digits output the raw table codes.

Test Plan:
1. Reset asserted mid-cycle -> digits = 0x888888 immediately and cur_entry = 0. First edge after release -> digits = 0xAAAAAA.
2. Write entry 2 digits 0..5 = 9,3,2,5,6,1 with mode = 0 and sel = 2 -> digits = 0x165239 one edge after the last write. Then sel = 7 -> all BLANK. With ENTRIES = 6, sel = 7 -> digits and cur_entry hold.
3. mode = 1, dwell = 3, tick every cycle from entry 0 -> cur_entry advances every 3 edges: 0,1,...,7,0. wrap pulses once on the 7 -> 0 edge. dwell = 0 -> advance on every tick.
4. mode = 1 with tick pulsed once every 4 cycles and dwell = 2 -> advance every 8 cycles. Drop mode to 0 with sel = 5 -> next edge cur_entry = 5 and the counter is 0.
5. Write to the displayed entry on the same edge the auto advance fires -> new entry shown; the written entry shows the new data when it is next displayed.
6. LZ_BLANK_EN defined, entry = 0,0,0,4,0,0 (digit 5..0) -> output A,A,A,4,0,0. Entry all 0 -> A,A,A,A,A,0.

Source files
------------

// File: rtl/digit_msg_seq.sv
// Writable multi-digit message table with manual/auto entry sequencing for the 7-seg path.
// Optional LZ_BLANK_EN: leading-zero suppression on the registered digits.
module digit_msg_seq #(
  parameter int         DIGITS  = 6,
  parameter int         ENTRIES = 8,
  parameter int         SEL_W   = 3,
  parameter int         DWELL_W = 16,
  parameter logic [3:0] BLANK   = 4'd10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  tick,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_entry,
  input  logic [SEL_W-1:0]      wr_digit,
  input  logic [3:0]            wr_data,
  output logic [4*DIGITS-1:0]   digits,
  output logic [SEL_W-1:0]      cur_entry,
  output logic                  wrap
);

  // state      | meaning
  // ST_MANUAL  | mode=0: entry follows sel (if in range), counter held at 0
  // ST_COUNT   | mode=1: counting ticks toward the dwell limit
  // ST_ADVANCE | mode=1: dwell reached on this tick, step to next entry
  localparam logic [1:0] ST_MANUAL  = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_ADVANCE = 2'd2;

  logic [4*DIGITS-1:0] tbl_q [ENTRIES];
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [SEL_W-1:0]    cur_q, next_entry;
  logic [DWELL_W-1:0]  cnt_q, cnt_d, dwell_eff;
  logic                wrap_q, wrap_d;
  logic                at_end, last_entry;
  logic [1:0]          state;

  assign dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
  // >= rather than == so a dwell shortened mid-count still advances on the next tick
  assign at_end     = (cnt_q >= dwell_eff - DWELL_W'(1));
  assign last_entry = (cur_q == SEL_W'(ENTRIES - 1));

  always_comb begin
    if (!mode)                state = ST_MANUAL;
    else if (tick && at_end)  state = ST_ADVANCE;
    else                      state = ST_COUNT;
  end

  always_comb begin
    next_entry = cur_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    case (state)
      ST_MANUAL: begin
        cnt_d = '0;
        if (32'(sel) < ENTRIES) next_entry = sel;
      end
      ST_ADVANCE: begin
        cnt_d      = '0;
        next_entry = last_entry ? '0 : cur_q + SEL_W'(1);
        wrap_d     = last_entry;
      end
      default: begin
        if (tick) cnt_d = cnt_q + DWELL_W'(1);
      end
    endcase
  end

  // Reads the pre-edge table, so a same-edge write shows up one edge later
  always_comb begin
    digits_d = {DIGITS{BLANK}};
    for (int e = 0; e < ENTRIES; e++) begin
      if (next_entry == SEL_W'(e)) digits_d = tbl_q[e];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < ENTRIES; e++) tbl_q[e] <= {DIGITS{BLANK}};
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (wr_en && 32'(wr_entry) == e && 32'(wr_digit) == d)
            tbl_q[e][4*d +: 4] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= {DIGITS{4'h8}};
      cur_q    <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      cur_q    <= next_entry;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
    end
  end

  assign cur_entry = cur_q;
  assign wrap      = wrap_q;

`ifdef LZ_BLANK_EN
  logic lead;
  always_comb begin
    digits = digits_q;
    lead   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && digits_q[4*i +: 4] == 4'd0) digits[4*i +: 4] = BLANK;
      else                                    lead = 1'b0;
    end
  end
`else
  assign digits = digits_q;
`endif

endmodule

// File: tb/tb_digit_msg_seq.sv
// Directed bench for digit_msg_seq: default 8-entry instance plus a 6-entry instance
// for the out-of-range manual select hold.
module tb_digit_msg_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        mode, tick, wr_en;
  logic [2:0]  sel, wr_entry, wr_digit;
  logic [3:0]  wr_data;
  logic [15:0] dwell;
  logic [23:0] digits8, digits6;
  logic [2:0]  cur8, cur6;
  logic        wrap8, wrap6;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  digit_msg_seq u_dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .tick(tick), .dwell(dwell),
    .wr_en(wr_en), .wr_entry(wr_entry), .wr_digit(wr_digit), .wr_data(wr_data),
    .digits(digits8), .cur_entry(cur8), .wrap(wrap8)
  );

  digit_msg_seq #(.ENTRIES(6)) u_dut6 (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .tick(tick), .dwell(dwell),
    .wr_en(wr_en), .wr_entry(wr_entry), .wr_digit(wr_digit), .wr_data(wr_data),
    .digits(digits6), .cur_entry(cur6), .wrap(wrap6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] e, input logic [2:0] d, input logic [3:0] v);
    wr_en = 1'b1; wr_entry = e; wr_digit = d; wr_data = v;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; tick = 1'b0; wr_en = 1'b0; sel = 3'd0;
    wr_entry = 3'd0; wr_digit = 3'd0; wr_data = 4'd0; dwell = 16'd3;

    // Reset and lamp test
    step(); step();
    reset = 1'b0;
    chk("lamp_digits", 32'(digits8), 32'h888888);
    chk("lamp_cur", 32'(cur8), 0);
    chk("lamp_wrap", 32'(wrap8 | wrap6), 0);
    step();
    chk("first_edge_blank", 32'(digits8), 32'hAAAAAA);

    // Manual write of entry 2
    sel = 3'd2;
    wr(3'd2, 3'd0, 4'd9); wr(3'd2, 3'd1, 4'd3); wr(3'd2, 3'd2, 4'd2);
    wr(3'd2, 3'd3, 4'd5); wr(3'd2, 3'd4, 4'd6); wr(3'd2, 3'd5, 4'd1);
    chk("rbw_last_write", 32'(digits8), 32'hA65239);
    step();
    chk("entry2_digits", 32'(digits8), 32'h165239);
    chk("entry2_cur", 32'(cur8), 2);
    sel = 3'd7;
    step();
    chk("sel7_blank", 32'(digits8), 32'hAAAAAA);
    chk("sel7_cur", 32'(cur8), 7);
    chk("e6_hold_cur", 32'(cur6), 2);
    chk("e6_hold_digits", 32'(digits6), 32'h165239);
    sel = 3'd2;
    wr(3'd2, 3'd6, 4'd0); wr(3'd2, 3'd7, 4'd0);
    step();
    chk("bad_digit_ignored", 32'(digits8), 32'h165239);

    // Auto cycling, dwell 3, tick every cycle
    sel = 3'd0;
    step();
    chk("auto_start_cur", 32'(cur8), 0);
    mode = 1'b1; tick = 1'b1; dwell = 16'd3;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("auto3_cur_%0d", k), 32'(cur8), 32'((k / 3) % 8));
      chk($sformatf("auto3_wrap_%0d", k), 32'(wrap8), (k == 24) ? 1 : 0);
      if (k == 6) chk("auto3_digits_e2", 32'(digits8), 32'h165239);
    end
    dwell = 16'd0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("dwell0_cur_%0d", k), 32'(cur8), 32'(k));
    end

    // Sparse ticks, dwell 2
    dwell = 16'd2;
    for (int c = 0; c < 16; c++) begin
      tick = (c % 4 == 0);
      step();
      chk($sformatf("sparse_cur_%0d", c), 32'(cur8), (c < 4) ? 4 : (c < 12) ? 5 : 6);
    end
    tick = 1'b1;
    step();
    chk("pre_drop_cur", 32'(cur8), 6);
    tick = 1'b0; mode = 1'b0; sel = 3'd5;
    step();
    chk("drop_sel5_cur", 32'(cur8), 5);
    mode = 1'b1; tick = 1'b1;
    step();
    chk("cnt_cleared_hold", 32'(cur8), 5);
    step();
    chk("cnt_cleared_adv", 32'(cur8), 6);

    // Dwell shortened mid-count
    dwell = 16'd3;
    step(); step();
    chk("shrink_pre", 32'(cur8), 6);
    dwell = 16'd2;
    step();
    chk("shrink_adv", 32'(cur8), 7);
    step();
    chk("shrink_hold", 32'(cur8), 7);
    step();
    chk("wrap2_cur", 32'(cur8), 0);
    chk("wrap2_pulse", 32'(wrap8), 1);
    tick = 1'b0;
    step();
    chk("wrap2_drop", 32'(wrap8), 0);
    chk("tick0_hold", 32'(cur8), 0);

    // Write to displayed entry on the advance edge
    tick = 1'b1;
    step();
    chk("wadv_pre", 32'(cur8), 0);
    wr(3'd0, 3'd0, 4'd7);
    chk("wadv_cur", 32'(cur8), 1);
    chk("wadv_digits", 32'(digits8), 32'hAAAAAA);
    tick = 1'b0; mode = 1'b0; sel = 3'd0;
    step();
    chk("wadv_revisit", 32'(digits8), 32'hAAAAA7);
    wr(3'd0, 3'd1, 4'd3);
    chk("same_entry_rbw", 32'(digits8), 32'hAAAAA7);
    step();
    chk("same_entry_new", 32'(digits8), 32'hAAAA37);

    // Leading-zero pattern in entry 3
    sel = 3'd3;
    wr(3'd3, 3'd0, 4'd0); wr(3'd3, 3'd1, 4'd0); wr(3'd3, 3'd2, 4'd4);
    wr(3'd3, 3'd3, 4'd0); wr(3'd3, 3'd4, 4'd0); wr(3'd3, 3'd5, 4'd0);
    step();
`ifdef LZ_BLANK_EN
    chk("lz_000400", 32'(digits8), 32'hAAA400);
`else
    chk("raw_000400", 32'(digits8), 32'h000400);
`endif
    wr(3'd3, 3'd2, 4'd0);
    step();
`ifdef LZ_BLANK_EN
    chk("lz_all_zero", 32'(digits8), 32'hAAAAA0);
`else
    chk("raw_all_zero", 32'(digits8), 32'h000000);
`endif

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("async_rst_digits", 32'(digits8), 32'h888888);
    chk("async_rst_cur", 32'(cur8), 0);
    chk("async_rst_wrap", 32'(wrap8), 0);
    #2 reset = 1'b0;
    step();
    chk("rst_table_cleared", 32'(digits8), 32'hAAAAAA);
    chk("rst_cur_sel3", 32'(cur8), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
